// File: rtl/onehot_encoder_pipe_if.sv
// Handshake bundle for onehot_encoder_pipe: one-hot input word stream in, encoded index stream out.
// Latency: n/a (wires only).
// Backpressure: in_ready gates the producer, out_ready gates the encoder output.
// Ports: code_in/in_valid/in_ready (input side), code_out/zero_out/multi_out/out_valid/out_ready
//        (output side), err_count (multi-hot statistics).
// slave = the encoder, master = whoever drives words in and takes results out.
interface onehot_encoder_pipe_if #(
    parameter int BITS = 3
);
    logic [(1 << BITS)-1:0] code_in;
    logic                   in_valid;
    logic                   in_ready;
    logic [BITS-1:0]        code_out;
    logic                   zero_out;
    logic                   multi_out;
    logic                   out_valid;
    logic                   out_ready;
    logic [7:0]             err_count;

    modport slave (
        input  code_in, in_valid, out_ready,
        output in_ready, code_out, zero_out, multi_out, out_valid, err_count
    );

    modport master (
        output code_in, in_valid, out_ready,
        input  in_ready, code_out, zero_out, multi_out, out_valid, err_count
    );
endinterface

// File: rtl/onehot_encoder_pipe.sv
// One-hot to binary encoder (lowest set bit wins) behind a 2-entry skid buffer.
// Latency: 1 cycle from input transfer into an empty buffer to out_valid.
// Backpressure: in_ready is a register, low only when both entries are full; no out_ready->in_ready path.
// Ports: clk, rst (async, active high), bus (onehot_encoder_pipe_if.slave).
// Build option: define ONEHOT_ENCODER_MULTI_CHECK_EN to flag multi-hot words (multi_out) and count
// them in a saturating 8-bit err_count; otherwise both outputs are constant 0.
module onehot_encoder_pipe #(
    parameter int BITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    onehot_encoder_pipe_if.slave  bus
);
    localparam int W = 1 << BITS;

    typedef struct packed {
        logic            multi;
        logic            zero;
        logic [BITS-1:0] code;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        TWO
    } state_t;

    state_t state, state_nxt;
    entry_t head_q, tail_q, head_nxt, tail_nxt, in_enc;
    logic   in_ready_q;
    logic   out_valid_w;
    logic   in_xfer, out_xfer;

    // Words are encoded on entry so the buffer only stores the compact result.
    function automatic entry_t encode(input logic [W-1:0] x);
        entry_t e;
        e      = '0;
        e.zero = ~|x;
        // Scan downwards so the lowest set bit is the last one written.
        for (int i = W - 1; i >= 0; i--) begin
            if (x[i]) begin
                e.code = BITS'(i);
            end
        end
`ifdef ONEHOT_ENCODER_MULTI_CHECK_EN
        // Clearing the lowest set bit leaves something only if two or more were set.
        e.multi = |(x & (x - W'(1)));
`endif
        return e;
    endfunction

    assign in_enc      = encode(bus.code_in);
    assign out_valid_w = (state != EMPTY);
    assign in_xfer     = bus.in_valid & in_ready_q;
    assign out_xfer    = out_valid_w & bus.out_ready;

    always_comb begin
        state_nxt = state;
        head_nxt  = head_q;
        tail_nxt  = tail_q;
        case (state)
            EMPTY: begin
                if (in_xfer) begin
                    state_nxt = ONE;
                    head_nxt  = in_enc;
                end
            end
            ONE: begin
                case ({in_xfer, out_xfer})
                    2'b11: head_nxt = in_enc;
                    2'b10: begin
                        state_nxt = TWO;
                        tail_nxt  = in_enc;
                    end
                    2'b01: state_nxt = EMPTY;
                    default: ;
                endcase
            end
            TWO: begin
                // in_ready is low here, so in_valid cannot cause a transfer.
                if (out_xfer) begin
                    state_nxt = ONE;
                    head_nxt  = tail_q;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= EMPTY;
            in_ready_q <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
        end else begin
            state      <= state_nxt;
            // Registered from the next state so in_ready tracks "not full" without a comb path.
            in_ready_q <= (state_nxt != TWO);
            head_q     <= head_nxt;
            tail_q     <= tail_nxt;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_w;
    assign bus.code_out  = head_q.code;
    assign bus.zero_out  = head_q.zero;
    // Constant 0 when multi checking is not built: encode() never sets the flag.
    assign bus.multi_out = head_q.multi;

`ifdef ONEHOT_ENCODER_MULTI_CHECK_EN
    logic [7:0] err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 8'd0;
        end else if (in_xfer && in_enc.multi && (err_q != 8'hFF)) begin
            err_q <= err_q + 8'd1;
        end
    end

    assign bus.err_count = err_q;
`else
    assign bus.err_count = 8'd0;
`endif

endmodule

// File: doc/onehot_encoder_pipe.md
ONEHOT_ENCODER_PIPE -- requirements
Module: onehot_encoder_pipe

Interface
REQ-001 Parameter: BITS, default 3, width of the encoded index; input vector width is 2^BITS.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 code_in  input  2^BITS  one-hot (ideally) input vector.
REQ-005 in_valid  input  1  code_in valid this cycle.
REQ-006 in_ready  output  1  block can accept a word; registered output.
REQ-007 code_out  output  BITS  encoded index of the head word.
REQ-008 zero_out  output  1  head word had no bit set.
REQ-009 out_valid  output  1  code_out/zero_out valid.
REQ-010 out_ready  input  1  downstream accepts head word.
REQ-011 multi_out  output  1  head word had more than one bit set (see REQ-027).
REQ-012 err_count  output  8  saturating count of accepted multi-hot words (see REQ-027).

Function
REQ-013 Input transfer SHALL occur when in_valid and in_ready are both high; output transfer when out_valid and out_ready are both high.
REQ-014 Encoding SHALL be lowest-index priority: code_out = index of lowest set bit of the accepted code_in.
REQ-015 For an all-zero word, code_out SHALL be 0 and zero_out SHALL be 1; otherwise zero_out SHALL be 0.
REQ-016 Storage SHALL be a 2-entry skid buffer with FSM states EMPTY, ONE, TWO.
REQ-017 Transitions: EMPTY->ONE on input transfer. ONE->TWO on input transfer without output transfer. ONE->EMPTY on output transfer without input transfer. ONE->ONE on both or neither. TWO->ONE on output transfer. TWO->TWO otherwise.
REQ-018 in_ready SHALL be high in EMPTY and ONE and low in TWO; it SHALL be driven from a register, with no combinational path from out_ready.
REQ-019 out_valid SHALL be high in ONE and TWO.
REQ-020 Latency: a word accepted at edge N into EMPTY SHALL appear on the outputs after edge N, i.e. one cycle.
REQ-021 Ordering SHALL be strict FIFO; no word is dropped or duplicated under any in_valid/out_ready pattern.
REQ-022 Head outputs SHALL remain stable while out_valid is high and out_ready is low.
REQ-023 Simultaneous input and output transfer in ONE: the new word SHALL become head on the next cycle and the state stays ONE.
REQ-024 in_valid while in TWO SHALL be ignored, with no state change.

Reset
REQ-025 Asserting rst at any time, including mid-transfer, SHALL immediately force: state EMPTY, in_ready 0, out_valid 0, code_out 0, zero_out 0, multi_out 0, err_count 0.
REQ-026 in_ready SHALL rise on the first clock edge after rst deasserts; all buffered words are discarded.

Configuration
REQ-027 Macro ONEHOT_ENCODER_MULTI_CHECK_EN:
- Defined: multi_out flags any head word with two or more bits set (encoding still per REQ-014). err_count increments once per accepted multi-hot word and saturates at 255.
- Undefined: multi_out and err_count are tied to 0 and no checking logic is built.

Verification
REQ-028 BITS=3, after reset, send 8'b0001_0000 with out_ready=1 -> one cycle later out_valid=1, code_out=4, zero_out=0, multi_out=0.
REQ-029 Send 8'h00 -> code_out=0, zero_out=1.
REQ-030 Hold out_ready=0 and send 3 words -> first two accepted, in_ready=0 after the second, third held. Raise out_ready -> outputs in order, stable while stalled.
REQ-031 Continuous in_valid with out_ready=1 and words 1,2,4,...,128 -> one output per cycle, codes 0..7, in_ready never drops.
REQ-032 Macro defined: send 8'b1010_0000 -> code_out=5, multi_out=1, err_count=1. Send 300 multi-hot words -> err_count=255. Macro undefined: same stimulus -> multi_out=0, err_count=0.
REQ-033 Assert rst while in TWO -> all outputs per REQ-025 immediately (no clock edge needed). After release, in_ready=1 and the next word is the first output.
